// File: rtl/instruction_register_if.sv
// instruction_register_if: ROM fetch bus between controller and instruction register
interface instruction_register_if #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
);
  logic [DATA_W-1:0]   data;
  logic [1:0]          fetch;
  logic                rom_ena;
  logic                rom_read;
  logic [2:0]          ins;
  logic [2*DATA_W-4:0] ad_ir;
  logic                phase;
  logic                ins_valid;
  logic                opr_valid;
  logic                halted;
  logic [CNT_W-1:0]    fetch_cnt;
  modport master (
    output data, fetch, rom_ena, rom_read,
    input  ins, ad_ir, phase, ins_valid, opr_valid, halted, fetch_cnt
  );
  modport slave (
    input  data, fetch, rom_ena, rom_read,
    output ins, ad_ir, phase, ins_valid, opr_valid, halted, fetch_cnt
  );
endinterface

// File: rtl/instruction_register.sv
// instruction_register: captures opcode/operand bytes from ROM for the CPU controller
module instruction_register #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input logic clk,
  input logic rst,
  instruction_register_if.slave bus
);
  logic [2*DATA_W-1:0] ir;
  logic                phase;
  logic                ins_valid;
  logic                opr_valid;
  logic                halted;
  logic [CNT_W-1:0]    fetch_cnt;
  logic                cap;
  logic [2:0]          op;
  logic                op_long;
  // capture only on a genuine ROM fetch; register-read fetch codes lack rom_read
  always_comb begin
    cap     = (bus.fetch == 2'b01) & bus.rom_ena & bus.rom_read & ~halted;
    op      = bus.data[DATA_W-1 -: 3];
    op_long = ~op[2] & |op[1:0];
  end
  // opcode byte fills the high half and clears the low half; operand byte fills the low half
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ir        <= '0;
      phase     <= 1'b0;
      ins_valid <= 1'b0;
      opr_valid <= 1'b0;
      halted    <= 1'b0;
      fetch_cnt <= '0;
    end else if (cap) begin
      if (!phase) begin
        ir        <= {bus.data, {DATA_W{1'b0}}};
        ins_valid <= 1'b1;
        opr_valid <= 1'b0;
        fetch_cnt <= fetch_cnt + CNT_W'(1);
        phase     <= op_long;
        halted    <= &op;
      end else begin
        ir[DATA_W-1:0] <= bus.data;
        opr_valid      <= 1'b1;
        phase          <= 1'b0;
      end
    end
  end
  assign bus.ins       = ir[2*DATA_W-1 -: 3];
  assign bus.ad_ir     = ir[2*DATA_W-4:0];
  assign bus.phase     = phase;
  assign bus.ins_valid = ins_valid;
  assign bus.opr_valid = opr_valid;
  assign bus.halted    = halted;
  assign bus.fetch_cnt = fetch_cnt;
endmodule

// File: tb/tb_instruction_register.sv
// tb_instruction_register: directed checks of the instruction register
module tb_instruction_register;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  instruction_register_if bus ();
  instruction_register dut (.clk(clk), .rst(rst), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic idle();
    bus.fetch = 2'b00;
    bus.rom_ena = 1'b0;
    bus.rom_read = 1'b0;
  endtask
  task automatic cap(input logic [7:0] d);
    @(negedge clk);
    bus.data = d;
    bus.fetch = 2'b01;
    bus.rom_ena = 1'b1;
    bus.rom_read = 1'b1;
    @(negedge clk);
    idle();
  endtask
  task automatic chk_all(input string tag, input logic [2:0] ins, input logic [12:0] ad,
                         input logic ph, input logic iv, input logic ov, input logic h,
                         input logic [7:0] cnt);
    chk({tag, ".ins"}, 32'(bus.ins), 32'(ins));
    chk({tag, ".ad_ir"}, 32'(bus.ad_ir), 32'(ad));
    chk({tag, ".phase"}, 32'(bus.phase), 32'(ph));
    chk({tag, ".ins_valid"}, 32'(bus.ins_valid), 32'(iv));
    chk({tag, ".opr_valid"}, 32'(bus.opr_valid), 32'(ov));
    chk({tag, ".halted"}, 32'(bus.halted), 32'(h));
    chk({tag, ".fetch_cnt"}, 32'(bus.fetch_cnt), 32'(cnt));
  endtask
  initial begin
    bus.data = 8'h00;
    idle();
    repeat (2) @(negedge clk);
    chk_all("reset", 3'd0, 13'h0000, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;
    cap(8'h3F);
    chk_all("sto_opc", 3'b001, 13'h1F00, 1, 1, 0, 0, 8'd1);
    #2 rst = 1'b1;
    #1 chk_all("async_rst", 3'd0, 13'h0000, 0, 0, 0, 0, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    cap(8'h25);
    chk_all("first_cap", 3'b001, 13'h0500, 1, 1, 0, 0, 8'd1);
    cap(8'h11);
    chk_all("first_opr", 3'b001, 13'h0511, 0, 1, 1, 0, 8'd1);
    cap(8'h4A);
    chk_all("lda_opc", 3'b010, 13'h0A00, 1, 1, 0, 0, 8'd2);
    cap(8'h7C);
    chk_all("lda_opr", 3'b010, 13'h0A7C, 0, 1, 1, 0, 8'd2);
    cap(8'hA3);
    chk_all("add", 3'b101, 13'h0300, 0, 1, 0, 0, 8'd3);
    cap(8'h10);
    chk_all("nop_after_short", 3'b000, 13'h1000, 0, 1, 0, 0, 8'd4);
    @(negedge clk);
    bus.data = 8'hFF;
    bus.fetch = 2'b01;
    bus.rom_ena = 1'b1;
    bus.rom_read = 1'b0;
    @(negedge clk);
    bus.fetch = 2'b10;
    bus.rom_read = 1'b1;
    @(negedge clk);
    bus.fetch = 2'b01;
    bus.rom_ena = 1'b0;
    @(negedge clk);
    idle();
    chk_all("no_strobe", 3'b000, 13'h1000, 0, 1, 0, 0, 8'd4);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.data = 8'h00;
    bus.fetch = 2'b01;
    bus.rom_ena = 1'b1;
    bus.rom_read = 1'b1;
    repeat (255) @(negedge clk);
    chk("wrap_255", 32'(bus.fetch_cnt), 32'hFF);
    @(negedge clk);
    idle();
    chk_all("wrap_0", 3'b000, 13'h0000, 0, 1, 0, 0, 8'd0);
    cap(8'hE0);
    chk_all("halt", 3'b111, 13'h0000, 0, 1, 0, 1, 8'd1);
    cap(8'h20);
    cap(8'h20);
    chk_all("halt_frozen", 3'b111, 13'h0000, 0, 1, 0, 1, 8'd1);
    #1 rst = 1'b1;
    #1 chk_all("halt_rst", 3'd0, 13'h0000, 0, 0, 0, 0, 8'd0);
    rst = 1'b0;
    cap(8'h20);
    chk_all("after_halt", 3'b001, 13'h0000, 1, 1, 0, 0, 8'd1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
